// File: rtl/single_port_sram.sv
// single_port_sram: synchronous single-port SRAM with a shared tri-state data bus and 1-cycle registered reads
// Optional feature macro SRAM_RESET_CLEAR_EN: reset also clears every memory word to 0.
module single_port_sram #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] address,
   inout  wire  [WIDTH-1:0]      data,
   input  logic                  chip_select,
   input  logic                  write_enable,
   input  logic                  output_enable
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_q;
   logic             in_range;
   logic             wr;
   logic             rd;
   logic             drive;
   assign in_range = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
   assign wr       = rst_n && chip_select && write_enable && in_range;
   assign rd       = chip_select && !write_enable;
   assign drive    = rst_n && chip_select && output_enable && !write_enable;
   assign data     = drive ? rd_q : 'z;
`ifdef SRAM_RESET_CLEAR_EN
   // storage: cleared on reset, written on a qualified in-range write
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mem <= '{default: '0};
      else if (wr) mem[address] <= data;
`else
   // storage: no reset, written on a qualified in-range write
   always_ff @(posedge clk)
      if (wr) mem[address] <= data;
`endif
   // read register: captures the addressed word on a read, out-of-range reads return 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rd_q <= '0;
      else if (rd) rd_q <= in_range ? mem[address] : '0;
endmodule

// File: tb/tb_single_port_sram.sv
// tb_single_port_sram: randomized and directed check of single_port_sram against an array model
module tb_single_port_sram;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [3:0]  addr = 0;
   logic        cs = 0, we = 0, oe = 0;
   logic        drv_en = 0;
   logic [31:0] drv = 0;
   tri1  [31:0] data;
   int          vectors = 0;
   int          fails = 0;
   logic [31:0] r [16];
   logic [31:0] ref_mem [16];
   bit          ref_v [16];
   logic [31:0] ref_rd = 0;
   bit          ref_ok = 1;

   assign data = drv_en ? drv : 'z;

   single_port_sram dut (
      .clk(clk), .rst_n(rst_n), .address(addr), .data(data),
      .chip_select(cs), .write_enable(we), .output_enable(oe)
   );

   always #5 clk = ~clk;

   // behavioural model: plain array, read register, reset behaviour
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_rd = 0;
         ref_ok = 1;
`ifdef SRAM_RESET_CLEAR_EN
         for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 0;
            ref_v[i] = 1;
         end
`endif
      end else if (cs && we) begin
         ref_mem[addr] = drv_en ? drv : 32'hFFFF_FFFF;
         ref_v[addr] = 1;
      end else if (cs) begin
         ref_rd = ref_mem[addr];
         ref_ok = ref_v[addr];
      end
   end

   // bus compare every cycle: DUT value when it should drive, otherwise the bench driver or the pull-up
   always @(negedge clk) begin
      logic [31:0] exp;
      bit chk;
      chk = 1;
      if (rst_n && cs && oe && !we) begin
         exp = ref_rd;
         chk = ref_ok;
      end else exp = drv_en ? drv : 32'hFFFF_FFFF;
      if (chk) begin
         vectors++;
         if (data !== exp) begin
            fails++;
            $display("FAIL bus t=%0t addr=%0d cs=%b we=%b oe=%b got=%h exp=%h", $time, addr, cs, we, oe, data, exp);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   task automatic cyc(input logic c, input logic w, input logic o, input logic [3:0] a,
                      input logic de, input logic [31:0] dv);
      cs = c; we = w; oe = o; addr = a; drv_en = de; drv = dv;
      @(posedge clk);
      #1;
   endtask

   task automatic read_all(input string name);
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 1, 4'(i), 0, 0);
         chk(name, data, r[i]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ref_v[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hiz", data, 32'hFFFF_FFFF);
      rst_n = 1;
      for (int i = 0; i < 16; i++) begin
         r[i] = $urandom;
         cyc(1, 1, 0, 4'(i), 1, r[i]);
      end
      read_all("t1_read");
      for (int i = 0; i < 16; i++) cyc(0, 1, 0, 4'(i), 1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("cs0_hiz", data, 32'hFFFF_FFFF);
      read_all("t2_read");
      for (int i = 0; i < 16; i++) begin
         cyc(1, 0, 0, 4'(i), 1, 0);
         chk("oe0_bench", data, 32'h0);
      end
      read_all("t3_read");
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 4'(i), 0, 0);
      rst_n = 0;
      #1;
      chk("rst_mid_hiz", data, 32'hFFFF_FFFF);
      cyc(1, 1, 0, 3, 1, 32'h1234_5678);
      cyc(1, 0, 1, 3, 0, 0);
      chk("rst_read_hiz", data, 32'hFFFF_FFFF);
      rst_n = 1;
      cyc(1, 0, 1, 3, 0, 0);
`ifdef SRAM_RESET_CLEAR_EN
      chk("post_rst_a3", data, 32'h0);
`else
      chk("post_rst_a3", data, r[3]);
`endif
      cyc(1, 1, 0, 15, 1, 32'hDEAD_BEEF);
      cyc(1, 1, 0, 0, 1, 32'h1);
      cyc(1, 0, 1, 15, 0, 0);
      chk("a15", data, 32'hDEAD_BEEF);
      cyc(1, 0, 1, 0, 0, 0);
      chk("a0", data, 32'h1);
      for (int i = 0; i < 16; i++) cyc(1, 1, 0, 4'(i), 1, $urandom);
      for (int n = 0; n < 500; n++) begin
         logic c, w, o, de;
         c = $urandom_range(0, 3) != 0;
         w = $urandom_range(0, 1) != 0;
         o = $urandom_range(0, 1) != 0;
         de = !(c && o && !w) && ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 49) == 0) rst_n = 0;
         cyc(c, w, o, 4'($urandom_range(0, 15)), de, $urandom);
         rst_n = 1;
      end
      cyc(0, 0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
